// File: rtl/miller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miller_pkg: shared state encoding, error codes and CRC constants. Rev 1.0
// ---------------------------------------------------------------------------
package miller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HUNT    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4
  } state_e;

  localparam logic [2:0]  ERR_NONE          = 3'd0;
  localparam logic [2:0]  ERR_TIMEOUT       = 3'd1;
  localparam logic [2:0]  ERR_BAD_LEN       = 3'd2;
  localparam logic [2:0]  ERR_CRC           = 3'd3;
  localparam logic [2:0]  ERR_OVERFLOW      = 3'd4;

  localparam logic [7:0]  CRC_POLY          = 8'h07;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h7E7E;

endpackage
`default_nettype wire

// File: rtl/miller_rx_ctrl_crc8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miller_crc8: bit-serial CRC8, MSB-first, init 0, no reflection. Rev 1.0
// ---------------------------------------------------------------------------
module miller_crc8
  import miller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ din) ? CRC_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 8'h00;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/miller_rx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miller_rx_ctrl: frame receiver (sync, LEN, payload, CRC8) with 1-deep output.
// Rev 1.0
// ---------------------------------------------------------------------------
module miller_rx_ctrl
  import miller_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_in_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic [2:0] frame_err,
  output logic       err_strobe,
  output logic [7:0] frame_len,
  output logic       busy
);

  localparam int unsigned      TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [8:0]       MAX_LEN_W = 9'(MAX_LEN);

  state_e           state_q, state_d;
  logic [15:0]      sync_q, sync_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             err_strobe_q, err_strobe_d;
  logic [2:0]       frame_err_q, frame_err_d;
  logic [7:0]       frame_len_q, frame_len_d;

  logic             crc_clr, crc_en;
  logic [7:0]       crc_val;
  logic [15:0]      sync_shift;
  logic [7:0]       rx_byte;

  assign sync_shift = {sync_q[14:0], bit_in};
  assign rx_byte    = {sh_q[6:0], bit_in};

  miller_crc8 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (bit_in),
    .crc (crc_val)
  );

  always_comb begin
    state_d       = state_q;
    sync_d        = sync_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_d         = tmo_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = byte_valid_q && !byte_ready;
    frame_len_d   = frame_len_q;
    frame_err_d   = frame_err_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    err_strobe_d  = 1'b0;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;

    // Dropping enable silently abandons whatever is in progress.
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
          sync_d  = '0;
        end
        ST_HUNT: begin
          if (bit_in_valid) begin
            sync_d = sync_shift;
            if (sync_shift == SYNC_WORD) begin
              state_d       = ST_LEN;
              frame_start_d = 1'b1;
              bit_cnt_d     = '0;
              byte_cnt_d    = '0;
              sh_d          = '0;
              tmo_d         = '0;
              crc_clr       = 1'b1;
            end
          end
        end
        default: begin
          if (bit_in_valid) begin
            tmo_d     = '0;
            sh_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            crc_en    = (state_q != ST_CRC);
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_LEN: begin
                  frame_len_d = rx_byte;
                  if (rx_byte == 8'h00 || {1'b0, rx_byte} > MAX_LEN_W) begin
                    err_strobe_d = 1'b1;
                    frame_err_d  = ERR_BAD_LEN;
                    state_d      = ST_HUNT;
                    sync_d       = '0;
                  end else begin
                    state_d = ST_PAYLOAD;
                  end
                end
                ST_PAYLOAD: begin
                  // Pending byte is kept; the new one is what gets dropped.
                  if (byte_valid_q && !byte_ready) begin
                    err_strobe_d = 1'b1;
                    frame_err_d  = ERR_OVERFLOW;
                    state_d      = ST_HUNT;
                    sync_d       = '0;
                  end else begin
                    byte_out_d   = rx_byte;
                    byte_valid_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 8'd1;
                    if (byte_cnt_q + 8'd1 == frame_len_q) state_d = ST_CRC;
                  end
                end
                default: begin
                  if (rx_byte == crc_val) begin
                    frame_done_d = 1'b1;
                  end else begin
                    err_strobe_d = 1'b1;
                    frame_err_d  = ERR_CRC;
                  end
                  state_d = ST_HUNT;
                  sync_d  = '0;
                end
              endcase
            end
          end else if (tmo_q == TMO_LAST) begin
            err_strobe_d = 1'b1;
            frame_err_d  = ERR_TIMEOUT;
            state_d      = ST_HUNT;
            sync_d       = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sync_q        <= '0;
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_strobe_q  <= 1'b0;
      frame_err_q   <= ERR_NONE;
      frame_len_q   <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_q         <= tmo_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      err_strobe_q  <= err_strobe_d;
      frame_err_q   <= frame_err_d;
      frame_len_q   <= frame_len_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign err_strobe  = err_strobe_q;
  assign frame_err   = frame_err_q;
  assign frame_len   = frame_len_q;
  assign busy        = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);

endmodule
`default_nettype wire
